// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin on ties; default is fixed data priority.
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_err,
    output logic                    m_req,
    output logic                    m_we,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_be,
    input  logic                    m_ack,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    busy
);

    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] to_cnt;
    logic                 grant_i;
    logic                 grant_d;
    logic                 pick_d;
    logic                 in_wait;
    logic                 finish;
    logic                 timeout;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_d;

    // Resetting to "data" hands the first tie to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_d <= 1'b1;
        end else if (grant_i || grant_d) begin
            last_grant_d <= grant_d;
        end
    end

    assign pick_d = d_req && !(if_req && last_grant_d);
`else
    assign pick_d = d_req;
`endif

    assign in_wait = (state == WAIT_I) || (state == WAIT_D);
    assign timeout = in_wait && !m_ack && (to_cnt >= CNT_LAST);
    assign finish  = in_wait && (m_ack || (to_cnt >= CNT_LAST));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req || if_req) begin
                    if (pick_d) begin
                        grant_d    = 1'b1;
                        state_next = WAIT_D;
                    end else begin
                        grant_i    = 1'b1;
                        state_next = WAIT_I;
                    end
                end
            end
            WAIT_I, WAIT_D: begin
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_be     <= '0;
            to_cnt   <= '0;
            if_ready <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            d_ready  <= 1'b0;
            d_err    <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if (grant_d) begin
                m_req   <= 1'b1;
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
                m_be    <= d_be;
                to_cnt  <= '0;
            end else if (grant_i) begin
                m_req   <= 1'b1;
                m_we    <= 1'b0;
                m_addr  <= if_addr;
                m_wdata <= '0;
                m_be    <= '1;
                to_cnt  <= '0;
            end

            if (in_wait && !m_ack && (to_cnt != CNT_MAX)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A late ack on the timeout cycle still counts as a normal completion.
            if (finish) begin
                m_req <= 1'b0;
                if (state == WAIT_I) begin
                    if_ready <= 1'b1;
                    if_err   <= timeout;
                    if_rdata <= timeout ? '0 : m_rdata;
                end else begin
                    d_ready <= 1'b1;
                    d_err   <= timeout;
                    d_rdata <= (timeout || m_we) ? '0 : m_rdata;
                end
            end

            if (state == DONE) begin
                if_ready <= 1'b0;
                if_err   <= 1'b0;
                d_ready  <= 1'b0;
                d_err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-timeline model, directed cases, random traffic.
module tb_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int T  = 15;
    localparam int BW = DW / 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [BW-1:0] d_be;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          d_err;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [BW-1:0] m_be;
    logic          m_ack;
    logic [DW-1:0] m_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Model: a transaction granted at cycle g with memory latency W occupies
    // cycles g+1..g+L with m_req (L = W+1, or T on timeout) and pulses ready at g+L+1.
    int            cyc = 0;
    bit            txn = 1'b0;
    int            g, L, t_w;
    bit            who_d, t_we, t_err;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, t_mem;
    logic [BW-1:0] t_be;
    bit            last_d = 1'b1;
    logic [DW-1:0] h_if = '0, h_d = '0;
    int            force_w = -1;
    bit            force_mem_en = 1'b0;
    logic [DW-1:0] force_mem = '0;

    logic          exp_m_req = 0, exp_m_we = 0, exp_busy = 0;
    logic [AW-1:0] exp_m_addr = '0;
    logic [DW-1:0] exp_m_wdata = '0, exp_if_rdata = '0, exp_d_rdata = '0;
    logic [BW-1:0] exp_m_be = '0;
    logic          exp_if_ready = 0, exp_if_err = 0, exp_d_ready = 0, exp_d_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 9)  return int'($urandom_range(0, 3));
        if (r == 9) return T - 1;
        if (r == 10) return T;
        if (r == 11) return T - 2;
        if (r == 12) return 100;
        return int'($urandom_range(0, 6));
    endfunction

    // Called at the negedge of cycle cyc once the request inputs are set.
    task automatic drive_cycle();
        int n;
        if (txn && t_w < T && cyc == g + 1 + t_w) begin
            m_ack   = 1'b1;
            m_rdata = t_mem;
        end else begin
            m_ack   = 1'b0;
            m_rdata = $urandom;
        end

        if (rst) begin
            txn    = 1'b0;
            last_d = 1'b1;
            h_if   = '0;
            h_d    = '0;
        end else if (!(txn && cyc <= g + L + 1) && (if_req || d_req)) begin
            who_d  = d_req && !(RR && if_req && last_d);
            last_d = who_d;
            g      = cyc;
            t_w    = (force_w >= 0) ? force_w : rand_wait();
            t_mem  = force_mem_en ? force_mem : $urandom;
            L      = (t_w >= T) ? T : t_w + 1;
            t_err  = (t_w >= T);
            txn    = 1'b1;
            if (who_d) begin
                t_we = d_we; t_addr = d_addr; t_wdata = d_wdata; t_be = d_be;
            end else begin
                t_we = 1'b0; t_addr = if_addr; t_wdata = '0; t_be = '1;
            end
        end

        n = cyc + 1;
        exp_m_req = 0; exp_busy = 0; exp_if_ready = 0; exp_if_err = 0; exp_d_ready = 0; exp_d_err = 0;
        if (!rst && txn && n >= g + 1 && n <= g + L) begin
            exp_m_req = 1; exp_busy = 1;
            exp_m_we = t_we; exp_m_addr = t_addr; exp_m_wdata = t_wdata; exp_m_be = t_be;
        end else if (!rst && txn && n == g + L + 1) begin
            exp_busy = 1;
            if (who_d) begin
                exp_d_ready = 1; exp_d_err = t_err;
                h_d = (t_err || t_we) ? '0 : t_mem;
            end else begin
                exp_if_ready = 1; exp_if_err = t_err;
                h_if = t_err ? '0 : t_mem;
            end
        end
        exp_if_rdata = h_if;
        exp_d_rdata  = h_d;
        @(negedge clk);
        cyc++;
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("m_req", m_req, exp_m_req);
            check("busy", busy, exp_busy);
            check("if_ready", if_ready, exp_if_ready);
            check("if_err", if_err, exp_if_err);
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_ready", d_ready, exp_d_ready);
            check("d_err", d_err, exp_d_err);
            check("d_rdata", d_rdata, exp_d_rdata);
            if (exp_m_req) begin
                check("m_we", m_we, exp_m_we);
                check("m_addr", m_addr, exp_m_addr);
                check("m_wdata", m_wdata, exp_m_wdata);
                check("m_be", m_be, exp_m_be);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        drive_cycle();
        rst = 1'b0;
    endtask

    bit   i_pend, i_cancel, d_pend, d_cancel;
    int   i_gap, d_gap, nresp;
    logic [3:0] order;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_be = '0; m_ack = 0; m_rdata = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_m_req", m_req, 1'b0);
        check("rst_ready", {if_ready, d_ready, if_err, d_err}, 4'b0);
        do_reset();

        // single fetch, zero-wait memory
        force_w = 0; force_mem_en = 1; force_mem = 32'h0050_0093;
        if_req = 1; if_addr = 32'h0;
        drive_cycle();
        check("f1_m_req_c1", m_req, 1'b1);
        check("f1_m_be", m_be, 4'hF);
        drive_cycle();
        check("f1_if_ready_c2", if_ready, 1'b1);
        check("f1_if_rdata_c2", if_rdata, 32'h0050_0093);
        if_req = 0;
        drive_cycle();
        check("f1_busy_c3", busy, 1'b0);

        // simultaneous requests, four responses
        force_mem_en = 0;
        do_reset();
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF; d_wdata = '0;
        nresp = 0; order = '0;
        for (int k = 0; k < 40 && nresp < 4; k++) begin
            drive_cycle();
            if (if_ready) begin order[nresp] = 1'b0; nresp++; end
            if (d_ready && nresp < 4) begin order[nresp] = 1'b1; nresp++; end
        end
        check("tie_count", nresp, 4);
        check("tie_order", order, RR ? 4'b1010 : 4'b1111);
        if_req = 0; d_req = 0;
        drive_cycle();
        drive_cycle();

        // store with three wait cycles
        force_w = 3;
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        drive_cycle();
        for (int k = 1; k <= 4; k++) begin
            check("st_m_req", m_req, 1'b1);
            check("st_fields", {m_we, m_addr, m_wdata, m_be}, {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011});
            drive_cycle();
        end
        check("st_d_ready_c5", d_ready, 1'b1);
        check("st_d_rdata", d_rdata, 32'h0);
        check("st_d_err", d_err, 1'b0);
        d_req = 0;
        drive_cycle();

        // load that never gets an ack
        force_w = 100;
        d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'hF;
        drive_cycle();
        for (int k = 1; k <= T; k++) begin
            check("to_m_req", m_req, 1'b1);
            drive_cycle();
        end
        check("to_d_ready_c16", d_ready, 1'b1);
        check("to_d_err_c16", d_err, 1'b1);
        check("to_d_rdata_c16", d_rdata, 32'h0);
        d_req = 0;
        drive_cycle();
        check("to_busy_c17", busy, 1'b0);

        // ack on the last allowed wait cycle
        force_w = T - 1; force_mem_en = 1; force_mem = 32'hCAFE_0001;
        if_req = 1; if_addr = 32'h80;
        drive_cycle();
        for (int k = 1; k <= T; k++) drive_cycle();
        check("late_if_ready", if_ready, 1'b1);
        check("late_if_err", if_err, 1'b0);
        check("late_if_rdata", if_rdata, 32'hCAFE_0001);
        if_req = 0;
        drive_cycle();

        // reset on the second wait cycle, then a fresh fetch
        force_w = 100; if_req = 1; if_addr = 32'h10;
        drive_cycle();
        drive_cycle();
        rst = 1; if_req = 0;
        drive_cycle();
        rst = 0;
        check("rstw_m_req", m_req, 1'b0);
        check("rstw_busy", busy, 1'b0);
        check("rstw_ready", if_ready, 1'b0);
        force_w = 0; force_mem = 32'h1111_2222; if_req = 1; if_addr = 32'h40;
        drive_cycle();
        drive_cycle();
        check("rstw_fresh_ready", if_ready, 1'b1);
        check("rstw_fresh_rdata", if_rdata, 32'h1111_2222);
        if_req = 0;
        drive_cycle();

        // random traffic
        force_w = -1; force_mem_en = 0;
        i_pend = 0; i_cancel = 0; d_pend = 0; d_cancel = 0; i_gap = 0; d_gap = 0;
        for (int k = 0; k < 3000; k++) begin
            if (exp_if_ready) begin i_pend = 0; i_cancel = 0; i_gap = int'($urandom_range(0, 3)); end
            if (exp_d_ready)  begin d_pend = 0; d_cancel = 0; d_gap = int'($urandom_range(0, 3)); end
            if (i_pend && txn && !who_d && cyc >= g + 1 && cyc <= g + L && $urandom_range(0, 19) == 0) begin
                i_pend = 0; i_cancel = 1;
            end
            if (d_pend && txn && who_d && cyc >= g + 1 && cyc <= g + L && $urandom_range(0, 19) == 0) begin
                d_pend = 0; d_cancel = 1;
            end
            if (!i_pend && !i_cancel) begin
                if (i_gap > 0) i_gap--;
                else begin i_pend = 1; if_addr = $urandom; end
            end
            if (!d_pend && !d_cancel) begin
                if (d_gap > 0) d_gap--;
                else begin
                    d_pend = 1; d_we = 1'($urandom); d_addr = $urandom;
                    d_wdata = $urandom; d_be = 4'($urandom);
                end
            end
            if (!i_pend) if_addr = $urandom;
            if (!d_pend) begin
                d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            end
            if_req = i_pend;
            d_req  = d_pend;
            rst = ($urandom_range(0, 299) == 0);
            if (rst) begin i_cancel = 0; d_cancel = 0; end
            drive_cycle();
        end
        rst = 0; if_req = 0; d_req = 0;
        for (int k = 0; k < 20; k++) drive_cycle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing one single-ported unified instruction/data memory between instruction fetch and the load/store data path.
- Serialises requests into one outstanding memory transaction.
- Returns read data with a one-cycle ready pulse to the winning requester.
- Aborts with an error if the memory fails to acknowledge within a bounded number of cycles.
- Sits between fetch/memory stages and the shared memory; ready gates PC advance and writeback.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- ADDR_WIDTH, 32, address width
- TIMEOUT_CYCLES, 15, max WAIT cycles without m_ack before abort; ≥1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_ready  out  1  one-cycle response pulse
- if_rdata  out  DATA_WIDTH  fetched word, held until next fetch response
- if_err  out  1  timeout flag, valid only with if_ready
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  byte enables
- d_ready  out  1  one-cycle response pulse
- d_rdata  out  DATA_WIDTH  load data, held until next data response
- d_err  out  1  timeout flag, valid only with d_ready
- m_req  out  1  memory request, registered
- m_we, m_addr, m_wdata, m_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered transaction fields
- m_ack  in  1  memory completion, may be combinational to m_req
- m_rdata  in  DATA_WIDTH  read data, valid with m_ack
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WAIT_I, WAIT_D, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner and latch its fields into m_* registers.
  - Fetch: m_we=0, m_be=all ones, m_wdata=0.
  - Set m_req=1 and go to WAIT_I or WAIT_D.
- Fixed priority (default): d_req wins over if_req.
- WAIT_x, m_ack=1 this cycle:
  - Next edge: m_req←0, x_ready←1, x_err←0.
  - x_rdata←m_rdata for reads; d_rdata←0 for stores.
  - Go to DONE.
- WAIT_x, no m_ack:
  - Timeout counter increments.
  - On the TIMEOUT_CYCLES-th consecutive no-ack WAIT cycle, next edge: m_req←0, x_ready←1, x_err←1, x_rdata←0; go to DONE.
  - m_ack on the timeout cycle wins; treat as normal completion.
- DONE:
  - Ready pulse visible; no grant is made this cycle.
  - Always go to IDLE next edge, clearing ready and err.
  - Requesters drop or change req by the cycle after ready.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1); cleared on every grant; saturates, never wraps.
- m_* fields are stable for the whole WAIT state, whatever requesters do.
- Requester req deasserted mid-WAIT: transaction still completes; ready still pulses.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- rst mid-transaction: next edge forces m_req=0 and IDLE; the in-flight memory transaction is abandoned with no ready pulse.
- Cycle-level sequence with request seen in IDLE at cycle 0:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: m_req high.
  - Earliest m_ack: cycle 1.
  - Ready: cycle 2.
  - Next grant possible: cycle 3.
- Best-case throughput: one transaction per 3 cycles.
- Memory with W wait cycles: ready at cycle 2+W.
- Timeout:
  - m_req high for exactly TIMEOUT_CYCLES cycles.
  - Error ready at cycle TIMEOUT_CYCLES+1.

## Configuration
- ARB_ROUND_ROBIN_EN:
  - Defined: round-robin on simultaneous requests; the port not granted last wins.
  - last_grant register resets to "data", so the first tie goes to fetch.
  - A sole requester always wins; a timeout still counts as a grant.
  - Undefined: fixed data priority; no last_grant register.

## Test plan
- Single fetch, zero-wait memory (m_ack=m_req, m_rdata=0x00500093), if_addr=0x0: m_req at cycle 1, if_ready and if_rdata=0x00500093 at cycle 2, busy low at cycle 3.
- Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011, ack after 3 wait cycles: m_* fields stable for 4 cycles, d_ready at cycle 5, d_rdata=0, d_err=0.
- if_req and d_req asserted together, both held and re-asserted after each ready for 4 responses:
  - Without ARB_ROUND_ROBIN_EN: all 4 grants go to data; fetch starves.
  - With ARB_ROUND_ROBIN_EN: order is I, D, I, D.
- m_ack never asserted, TIMEOUT_CYCLES=15: m_req high cycles 1–15, d_ready and d_err=1 at cycle 16, d_rdata=0, IDLE at cycle 17.
- m_ack first asserted on the 15th WAIT cycle: normal completion, err=0, data returned.
- rst asserted on the 2nd WAIT cycle: next cycle m_req=0, busy=0, no ready pulse; a fresh fetch afterwards completes normally.
